pixel_sink_vga: RTL

- Consumer end of the pixel stream (x, y, colour, plot) that the game datapath produces while it sweeps the 160x120 screen.
- Stores each plotted pixel in an on-chip 160x120x3 frame buffer.
- Independently scans the buffer out as 640x480@60 VGA, scaling each stored pixel 4x4, for the DE2 DAC.
- Sits between the game datapath and the board VGA pins.

---
 rtl/pixel_sink_vga.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pixel_sink_vga.sv
// 160x120x3 frame buffer fed by the game pixel stream, scanned out as 640x480@60 VGA with 4x4 replication.
// Two pixel ticks from counters to pins, no back-pressure; define OOB_FLAG_EN for the sticky oob_err output.
module pixel_sink_vga #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SCALE_LOG2 = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [9:0] vga_r,
  output logic [9:0] vga_g,
  output logic [9:0] vga_b
`ifdef OOB_FLAG_EN
  ,
  output logic       oob_err
`endif
);

  localparam int FB_DEPTH = 160 * 120;

  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [2:0]  mem [0:FB_DEPTH-1];
  logic        pix_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        in_range;
  logic        vis;
  logic [14:0] waddr;
  logic [14:0] raddr;
  logic [14:0] vrow;
  logic [14:0] hcol;
  logic [2:0]  pix;
  logic        hs1;
  logic        vs1;
  logic        vis1;

  assign vga_sync_n = 1'b0;

  assign in_range = (x < 8'd160) && (y < 7'd120);
  assign waddr    = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};

  assign vis  = (hcount < H_VIS) && (vcount < V_VIS);
  assign vrow = 15'(vcount >> SCALE_LOG2);
  assign hcol = 15'(hcount >> SCALE_LOG2);

  // Off-screen positions read address 0 so the index never leaves the buffer.
  always_comb begin
    raddr = '0;
    if (vis) raddr = (vrow << 7) + (vrow << 5) + hcol;
  end

  // Read and write share one block so a same-address collision returns the old value.
  always_ff @(posedge clk) begin
    if (plot && in_range) mem[waddr] <= colour;
    if (pix_en) pix <= mem[raddr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_en      <= 1'b0;
      vga_clk     <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      vis1        <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else begin
      pix_en  <= ~pix_en;
      vga_clk <= ~pix_en;
      if (pix_en) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
        // Sync/visible decode travels alongside the buffer read to stay aligned with data.
        hs1  <= !((hcount >= HS_BEG) && (hcount <= HS_END));
        vs1  <= !((vcount >= VS_BEG) && (vcount <= VS_END));
        vis1 <= vis;

        vga_hs      <= hs1;
        vga_vs      <= vs1;
        vga_blank_n <= vis1;
        vga_r       <= vis1 ? {10{pix[2]}} : 10'd0;
        vga_g       <= vis1 ? {10{pix[1]}} : 10'd0;
        vga_b       <= vis1 ? {10{pix[0]}} : 10'd0;
      end
    end
  end

`ifdef OOB_FLAG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) oob_err <= 1'b0;
    else if (plot && !in_range) oob_err <= 1'b1;
  end
`endif

endmodule
